// File: rtl/adpll_cpu_regs_pkg.sv
// adpll_cpu_regs_pkg: modes, register addresses, configuration layout and reset defaults shared with the controller.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
// Contents: MODE_* codes, ADDR_* map, cfg_t shadow/committed layout, CFG_RST defaults, cfg_read/cfg_write helpers.
package adpll_cpu_regs_pkg;

   localparam logic [1:0] MODE_PD   = 2'd0;
   localparam logic [1:0] MODE_TEST = 2'd1;
   localparam logic [1:0] MODE_RX   = 2'd2;
   localparam logic [1:0] MODE_TX   = 2'd3;

   localparam int unsigned ADDR_FCW       = 0;
   localparam int unsigned ADDR_MODE      = 1;
   localparam int unsigned ADDR_GAIN      = 2;
   localparam int unsigned ADDR_IIR       = 3;
   localparam int unsigned ADDR_TEST      = 4;
   localparam int unsigned ADDR_DCO       = 5;
   localparam int unsigned ADDR_COMMIT    = 6;
   localparam int unsigned ADDR_STATUS    = 7;
   localparam int unsigned ADDR_LOCK_TIME = 8;

   localparam int FCW_BITS = 26;

   typedef struct packed {
      logic [FCW_BITS-1:0] fcw;
      logic [1:0]          mode;
      logic [3:0]          alpha_l;
      logic [3:0]          alpha_m;
      logic [3:0]          alpha_s_rx;
      logic [3:0]          alpha_s_tx;
      logic [3:0]          beta;
      logic [2:0]          lambda_rx;
      logic [2:0]          lambda_tx;
      logic [1:0]          iir_n_rx;
      logic [1:0]          iir_n_tx;
      logic [4:0]          fcw_mod;
      logic [4:0]          c_l_test;
      logic [7:0]          c_m_test;
      logic [7:0]          c_s_test;
      logic                dco_pd_test;
      logic                tdc_pd_test;
      logic                tdc_pd_inj_test;
      logic [2:0]          tdc_ctr_freq;
      logic [1:0]          dco_osc_gain;
   } cfg_t;

   localparam cfg_t CFG_RST = '{
      fcw: '0, mode: MODE_PD,
      alpha_l: 4'd14, alpha_m: 4'd8, alpha_s_rx: 4'd7, alpha_s_tx: 4'd4, beta: 4'd0,
      lambda_rx: 3'd2, lambda_tx: 3'd2, iir_n_rx: 2'd3, iir_n_tx: 2'd2, fcw_mod: 5'b01001,
      c_l_test: 5'd0, c_m_test: 8'd0, c_s_test: 8'd0,
      dco_pd_test: 1'b1, tdc_pd_test: 1'b1, tdc_pd_inj_test: 1'b1,
      tdc_ctr_freq: 3'b100, dco_osc_gain: 2'b10
   };

   // Register image of one configuration address; unmapped addresses and unused bits read 0.
   function automatic logic [31:0] cfg_read(input cfg_t c, input int unsigned addr);
      logic [31:0] r;
      r = '0;
      case (addr)
         ADDR_FCW:  r = {6'd0, c.fcw};
         ADDR_MODE: r = {30'd0, c.mode};
         ADDR_GAIN: r = {12'd0, c.beta, c.alpha_s_tx, c.alpha_s_rx, c.alpha_m, c.alpha_l};
         ADDR_IIR:  r = {11'd0, c.fcw_mod, 2'd0, c.iir_n_tx, 2'd0, c.iir_n_rx,
                         1'b0, c.lambda_tx, 1'b0, c.lambda_rx};
         ADDR_TEST: r = {1'b0, c.tdc_ctr_freq, 1'b0, c.tdc_pd_inj_test, c.tdc_pd_test,
                         c.dco_pd_test, c.c_s_test, c.c_m_test, 3'd0, c.c_l_test};
         ADDR_DCO:  r = {30'd0, c.dco_osc_gain};
         default:   r = '0;
      endcase
      return r;
   endfunction

   // Configuration after a bus write of d to addr; other addresses leave it untouched.
   function automatic cfg_t cfg_write(input cfg_t c, input int unsigned addr, input logic [31:0] d);
      cfg_t n;
      n = c;
      case (addr)
         ADDR_FCW:  n.fcw = d[FCW_BITS-1:0];
         ADDR_MODE: n.mode = d[1:0];
         ADDR_GAIN: {n.beta, n.alpha_s_tx, n.alpha_s_rx, n.alpha_m, n.alpha_l} = d[19:0];
         ADDR_IIR: begin
            n.lambda_rx = d[2:0];
            n.lambda_tx = d[6:4];
            n.iir_n_rx  = d[9:8];
            n.iir_n_tx  = d[13:12];
            n.fcw_mod   = d[20:16];
         end
         ADDR_TEST: begin
            n.c_l_test        = d[4:0];
            n.c_m_test        = d[15:8];
            n.c_s_test        = d[23:16];
            n.dco_pd_test     = d[24];
            n.tdc_pd_test     = d[25];
            n.tdc_pd_inj_test = d[26];
            n.tdc_ctr_freq    = d[30:28];
         end
         ADDR_DCO:  n.dco_osc_gain = d[1:0];
         default:   n = c;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/adpll_cpu_regs_lock_timer.sv
// adpll_lock_timer: channel_lock synchroniser, lock-acquisition timer and lock_lost flag.
// Latency: lock_sync trails channel_lock by 2 cycles; timer freezes on the edge after lock_sync rises.
// Backpressure: none; en=0 freezes every flop including the synchroniser.
// Ports: clk/rst, en, channel_lock, commit + commit_mode, clr_lost (W1C) in; lock_sync, lock_time, lock_lost out.
// Option: without ADPLL_REGS_LOCK_TIMER_EN only the synchroniser remains; lock_time and lock_lost tie to 0.
module adpll_lock_timer
   import adpll_cpu_regs_pkg::*;
#(
   parameter int LTW = 16
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           en,
   input  logic           channel_lock,
   input  logic           commit,
   input  logic [1:0]     commit_mode,
   input  logic           clr_lost,
   output logic           lock_sync,
   output logic [LTW-1:0] lock_time,
   output logic           lock_lost
);

   logic sync_q1;
   logic sync_q2;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q1 <= 1'b0;
         sync_q2 <= 1'b0;
      end else if (en) begin
         sync_q1 <= channel_lock;
         sync_q2 <= sync_q1;
      end
   end

   assign lock_sync = sync_q2;

`ifdef ADPLL_REGS_LOCK_TIMER_EN
   typedef enum logic [1:0] {T_IDLE, T_COUNT, T_DONE} tstate_t;

   tstate_t state;
   logic    lock_prev;
   logic    lock_rise;
   logic    lock_fall;

   assign lock_rise = sync_q2 & ~lock_prev;
   assign lock_fall = ~sync_q2 & lock_prev;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= T_IDLE;
         lock_prev <= 1'b0;
         lock_time <= '0;
         lock_lost <= 1'b0;
      end else if (en) begin
         lock_prev <= sync_q2;
         // A commit always restarts the measurement, even mid-count or after lock.
         if (commit) begin
            lock_time <= '0;
            state     <= (commit_mode == MODE_RX || commit_mode == MODE_TX) ? T_COUNT : T_IDLE;
         end else if (state == T_COUNT) begin
            if (lock_rise)
               state <= T_DONE;
            else if (lock_time != '1)
               lock_time <= lock_time + 1'b1;
         end
         // A lock drop seen in the same cycle as the software clear must not be lost.
         if (state == T_DONE && lock_fall)
            lock_lost <= 1'b1;
         else if (clr_lost)
            lock_lost <= 1'b0;
      end
   end
`else
   logic unused_timer_inputs;
   assign unused_timer_inputs = ^{commit, commit_mode, clr_lost};
   assign lock_time = '0;
   assign lock_lost = 1'b0;
`endif

endmodule

// File: rtl/adpll_cpu_regs.sv
// adpll_cpu_regs: CPU register bank feeding the ADPLL controller with double-buffered (shadow/commit) configuration.
// Latency: writes reach the shadow next edge; COMMIT moves every field to the outputs on one edge; reads 1 cycle.
// Backpressure: none; every bus access is accepted, en=0 freezes all state.
// Ports: clk/rst (async active-high), en, select/write/adress/data_in/data_out bus, channel_lock in,
//        committed FCW/mode/gain/IIR/test/DCO configuration out, cfg_pending out.
// Option: define ADPLL_REGS_LOCK_TIMER_EN to include the lock timer, LOCK_TIME register and lock_lost.
module adpll_cpu_regs
   import adpll_cpu_regs_pkg::*;
#(
   parameter int FCWW = 26,
   parameter int LTW  = 16,
   parameter int AW   = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic            select,
   input  logic            write,
   input  logic [AW-1:0]   adress,
   input  logic [31:0]     data_in,
   output logic [31:0]     data_out,
   input  logic            channel_lock,
   output logic [FCWW-1:0] FCW,
   output logic [1:0]      adpll_mode,
   output logic [3:0]      alpha_l,
   output logic [3:0]      alpha_m,
   output logic [3:0]      alpha_s_rx,
   output logic [3:0]      alpha_s_tx,
   output logic [3:0]      beta,
   output logic [2:0]      lambda_rx,
   output logic [2:0]      lambda_tx,
   output logic [1:0]      iir_n_rx,
   output logic [1:0]      iir_n_tx,
   output logic [4:0]      FCW_mod,
   output logic [4:0]      dco_c_l_word_test,
   output logic [7:0]      dco_c_m_word_test,
   output logic [7:0]      dco_c_s_word_test,
   output logic            dco_pd_test,
   output logic            tdc_pd_test,
   output logic            tdc_pd_inj_test,
   output logic [2:0]      tdc_ctr_freq,
   output logic [1:0]      dco_osc_gain,
   output logic            cfg_pending
);

   cfg_t           shadow;
   cfg_t           active;
   int unsigned    addr_i;
   logic           wr_en;
   logic           rd_en;
   logic           commit;
   logic           clr_lost;
   logic           lock_sync;
   logic           lock_lost;
   logic [LTW-1:0] lock_time;
   logic [31:0]    rd_mux;

   assign addr_i   = 32'(adress);
   assign wr_en    = select & write & en;
   assign rd_en    = select & ~write & en;
   assign commit   = wr_en && (addr_i == ADDR_COMMIT) && data_in[0];
   assign clr_lost = wr_en && (addr_i == ADDR_STATUS) && data_in[1];

   assign cfg_pending = (shadow != active);

   always_comb begin
      rd_mux = '0;
      case (addr_i)
         ADDR_STATUS:    rd_mux = {29'd0, cfg_pending, lock_lost, lock_sync};
         ADDR_LOCK_TIME: rd_mux = 32'(lock_time);
         default:        rd_mux = cfg_read(shadow, addr_i);
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow   <= CFG_RST;
         active   <= CFG_RST;
         data_out <= '0;
      end else if (en) begin
         if (wr_en)
            shadow <= cfg_write(shadow, addr_i, data_in);
         if (commit)
            active <= shadow;
         if (rd_en)
            data_out <= rd_mux;
      end
   end

   adpll_lock_timer #(.LTW(LTW)) u_lock_timer (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .channel_lock (channel_lock),
      .commit       (commit),
      .commit_mode  (shadow.mode),
      .clr_lost     (clr_lost),
      .lock_sync    (lock_sync),
      .lock_time    (lock_time),
      .lock_lost    (lock_lost)
   );

   assign FCW               = FCWW'(active.fcw);
   assign adpll_mode        = active.mode;
   assign alpha_l           = active.alpha_l;
   assign alpha_m           = active.alpha_m;
   assign alpha_s_rx        = active.alpha_s_rx;
   assign alpha_s_tx        = active.alpha_s_tx;
   assign beta              = active.beta;
   assign lambda_rx         = active.lambda_rx;
   assign lambda_tx         = active.lambda_tx;
   assign iir_n_rx          = active.iir_n_rx;
   assign iir_n_tx          = active.iir_n_tx;
   assign FCW_mod           = active.fcw_mod;
   assign dco_c_l_word_test = active.c_l_test;
   assign dco_c_m_word_test = active.c_m_test;
   assign dco_c_s_word_test = active.c_s_test;
   assign dco_pd_test       = active.dco_pd_test;
   assign tdc_pd_test       = active.tdc_pd_test;
   assign tdc_pd_inj_test   = active.tdc_pd_inj_test;
   assign tdc_ctr_freq      = active.tdc_ctr_freq;
   assign dco_osc_gain      = active.dco_osc_gain;

endmodule

// File: tb/tb_adpll_cpu_regs.sv
// tb_adpll_cpu_regs: randomized and directed bus traffic against a register-image reference model.
// Latency: model advances on each rising edge; outputs compared every cycle just after the falling edge.
// Backpressure: n/a.
`timescale 1ns/1ps
module tb_adpll_cpu_regs;
   localparam int FCWW = 26;
   localparam int LTW  = 16;
   localparam int AW   = 5;
`ifdef ADPLL_REGS_LOCK_TIMER_EN
   localparam bit TIMER_EN = 1'b1;
`else
   localparam bit TIMER_EN = 1'b0;
`endif
   localparam int MAXT = (1 << LTW) - 1;

   logic            clk = 1'b0;
   logic            rst, en, select, write, channel_lock;
   logic [AW-1:0]   adress;
   logic [31:0]     data_in, data_out;
   logic [FCWW-1:0] FCW;
   logic [1:0]      adpll_mode, iir_n_rx, iir_n_tx, dco_osc_gain;
   logic [3:0]      alpha_l, alpha_m, alpha_s_rx, alpha_s_tx, beta;
   logic [2:0]      lambda_rx, lambda_tx, tdc_ctr_freq;
   logic [4:0]      FCW_mod, dco_c_l_word_test;
   logic [7:0]      dco_c_m_word_test, dco_c_s_word_test;
   logic            dco_pd_test, tdc_pd_test, tdc_pd_inj_test, cfg_pending;

   always #5 clk = ~clk;

   adpll_cpu_regs #(.FCWW(FCWW), .LTW(LTW), .AW(AW)) dut (
      .clk(clk), .rst(rst), .en(en), .select(select), .write(write), .adress(adress),
      .data_in(data_in), .data_out(data_out), .channel_lock(channel_lock), .FCW(FCW),
      .adpll_mode(adpll_mode), .alpha_l(alpha_l), .alpha_m(alpha_m), .alpha_s_rx(alpha_s_rx),
      .alpha_s_tx(alpha_s_tx), .beta(beta), .lambda_rx(lambda_rx), .lambda_tx(lambda_tx),
      .iir_n_rx(iir_n_rx), .iir_n_tx(iir_n_tx), .FCW_mod(FCW_mod),
      .dco_c_l_word_test(dco_c_l_word_test), .dco_c_m_word_test(dco_c_m_word_test),
      .dco_c_s_word_test(dco_c_s_word_test), .dco_pd_test(dco_pd_test), .tdc_pd_test(tdc_pd_test),
      .tdc_pd_inj_test(tdc_pd_inj_test), .tdc_ctr_freq(tdc_ctr_freq), .dco_osc_gain(dco_osc_gain),
      .cfg_pending(cfg_pending)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: each configuration address is a 32-bit register image.
   localparam logic [31:0] MASK [6] = '{32'h03FF_FFFF, 32'h0000_0003, 32'h000F_FFFF,
                                        32'h001F_3377, 32'h77FF_FF1F, 32'h0000_0003};
   localparam logic [31:0] RSTV [6] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_478E,
                                        32'h0009_2322, 32'h4700_0000, 32'h0000_0002};
   logic [31:0] m_sh [6];
   logic [31:0] m_cm [6];
   logic [31:0] m_rd;
   int          m_phase;   // 0 idle, 1 counting, 2 locked
   int          m_cnt;
   bit          m_lost, m_s1, m_s2, m_sp;
   bit          cmp_on = 1'b0;

   function automatic bit m_pending();
      for (int i = 0; i < 6; i++)
         if (m_sh[i] != m_cm[i]) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 6; i++) begin
         m_sh[i] = RSTV[i];
         m_cm[i] = RSTV[i];
      end
      m_rd = 0; m_phase = 0; m_cnt = 0;
      m_lost = 0; m_s1 = 0; m_s2 = 0; m_sp = 0;
   endtask

   task automatic model_step();
      int a;
      bit rise, fall, wr, rd, cmt;
      a    = int'(adress);
      rise = m_s2 && !m_sp;
      fall = !m_s2 && m_sp;
      wr   = select && write;
      rd   = select && !write;
      cmt  = wr && a == 6 && data_in[0];
      if (rd) begin
         if (a <= 5)      m_rd = m_sh[a];
         else if (a == 7) m_rd = {29'd0, m_pending(), TIMER_EN && m_lost, m_s2};
         else if (a == 8) m_rd = TIMER_EN ? 32'(m_cnt) : 32'd0;
         else             m_rd = 0;
      end
      if (TIMER_EN) begin
         if (m_phase == 2 && fall)             m_lost = 1;
         else if (wr && a == 7 && data_in[1])  m_lost = 0;
         if (cmt) begin
            m_cnt   = 0;
            m_phase = (m_sh[1] >= 2) ? 1 : 0;
         end else if (m_phase == 1) begin
            if (rise)              m_phase = 2;
            else if (m_cnt < MAXT) m_cnt++;
         end
      end
      if (cmt) m_cm = m_sh;
      if (wr && a <= 5) m_sh[a] = data_in & MASK[a];
      m_sp = m_s2;
      m_s2 = m_s1;
      m_s1 = channel_lock;
   endtask

   always @(posedge clk) begin
      if (rst)     model_reset();
      else if (en) model_step();
   end

   // Per-cycle comparison of every observable output against the model.
   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (cmp_on) begin
            check("fcw", 32'(FCW), m_cm[0]);
            check("mode", 32'(adpll_mode), m_cm[1]);
            check("gains", {12'd0, beta, alpha_s_tx, alpha_s_rx, alpha_m, alpha_l}, m_cm[2]);
            check("iir", {11'd0, FCW_mod, 2'd0, iir_n_tx, 2'd0, iir_n_rx, 1'b0, lambda_tx,
                          1'b0, lambda_rx}, m_cm[3]);
            check("test", {1'b0, tdc_ctr_freq, 1'b0, tdc_pd_inj_test, tdc_pd_test, dco_pd_test,
                           dco_c_s_word_test, dco_c_m_word_test, 3'd0, dco_c_l_word_test}, m_cm[4]);
            check("dco_gain", 32'(dco_osc_gain), m_cm[5]);
            check("pending", 32'(cfg_pending), 32'(m_pending()));
            check("data_out", data_out, m_rd);
         end
      end
   end

   task automatic bus(input bit w, input int a, input logic [31:0] d);
      select  = 1'b1;
      write   = w;
      adress  = AW'(a);
      data_in = d;
      @(negedge clk);
      select  = 1'b0;
      write   = 1'b0;
   endtask

   initial begin : main
      int a;
      logic [31:0] lt;
      rst = 1'b1; en = 1'b1; select = 1'b0; write = 1'b0; adress = '0; data_in = '0;
      channel_lock = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      check("rst_fcw", 32'(FCW), 32'd0);
      check("rst_mode", 32'(adpll_mode), 32'd0);
      check("rst_alpha_l", 32'(alpha_l), 32'd14);
      check("rst_fcw_mod", 32'(FCW_mod), 32'd9);
      check("rst_dco_gain", 32'(dco_osc_gain), 32'd2);
      check("rst_data_out", data_out, 32'd0);
      check("rst_pending", 32'(cfg_pending), 32'd0);
      rst = 1'b0;
      cmp_on = 1'b1;
      @(negedge clk);

      bus(0, 2, 0);
      check("rd_rst_addr2", data_out, 32'h0000_478E);
      bus(0, 3, 0);
      check("rd_rst_addr3", data_out, 32'h0009_2322);
      bus(1, 2, 32'h0000_4787);
      bus(0, 2, 0);
      check("readback_addr2", data_out, 32'h0000_4787);
      bus(0, 9, 0);
      check("rd_addr9", data_out, 32'd0);

      bus(1, 0, 32'h00A3_2000);
      bus(1, 1, 32'd2);
      check("shadow_fcw_held", 32'(FCW), 32'd0);
      check("shadow_mode_held", 32'(adpll_mode), 32'd0);
      check("shadow_pending", 32'(cfg_pending), 32'd1);
      bus(1, 6, 32'd1);
      check("commit_fcw", 32'(FCW), 32'h00A3_2000);
      check("commit_mode", 32'(adpll_mode), 32'd2);
      check("commit_alpha_l", 32'(alpha_l), 32'd7);
      check("commit_pending", 32'(cfg_pending), 32'd0);

      repeat (500) @(negedge clk);
      channel_lock = 1'b1;
      repeat (10) @(negedge clk);
      bus(0, 8, 0);
      lt = data_out;
      check("lock_time_range", 32'(TIMER_EN ? (lt >= 501 && lt <= 503) : (lt == 0)), 32'd1);
      repeat (20) @(negedge clk);
      bus(0, 8, 0);
      check("lock_time_frozen", data_out, TIMER_EN ? 32'd502 : 32'd0);
      bus(0, 7, 0);
      check("status_locked", data_out, 32'd1);

      channel_lock = 1'b0;
      repeat (4) @(negedge clk);
      bus(0, 7, 0);
      check("status_lost", data_out, TIMER_EN ? 32'b010 : 32'b000);
      bus(1, 7, 32'd2);
      bus(0, 7, 0);
      check("status_w1c", data_out, 32'd0);

      // Clear lands on the edge that sees the synchronised falling edge.
      channel_lock = 1'b1;
      repeat (5) @(negedge clk);
      channel_lock = 1'b0;
      repeat (2) @(negedge clk);
      bus(1, 7, 32'd2);
      bus(0, 7, 0);
      check("w1c_race", data_out, TIMER_EN ? 32'b010 : 32'b000);

      en = 1'b0;
      bus(1, 0, 32'h0000_0155);
      bus(1, 6, 32'd1);
      en = 1'b1;
      check("en0_fcw", 32'(FCW), 32'h00A3_2000);
      check("en0_pending", 32'(cfg_pending), 32'd0);
      bus(0, 0, 0);
      check("en0_shadow", data_out, 32'h00A3_2000);

      for (int i = 0; i < 4000; i++) begin
         en = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 59) == 0) channel_lock = ~channel_lock;
         select  = 1'($urandom_range(0, 1));
         write   = 1'($urandom_range(0, 1));
         a       = int'($urandom_range(0, 11));
         if (a == 11) a = 31;
         adress  = AW'(a);
         data_in = $urandom;
         if (a == 6) data_in[0] = ($urandom_range(0, 2) == 0);
         @(negedge clk);
      end
      select = 1'b0; write = 1'b0; en = 1'b1;
      @(negedge clk);

      // Asynchronous reset with a commit on the bus and edits pending.
      bus(1, 0, 32'h0123_4567);
      select = 1'b1; write = 1'b1; adress = AW'(6); data_in = 32'd1;
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      check("arst_fcw", 32'(FCW), 32'd0);
      check("arst_alpha_l", 32'(alpha_l), 32'd14);
      check("arst_pending", 32'(cfg_pending), 32'd0);
      check("arst_data_out", data_out, 32'd0);
      @(negedge clk);
      select = 1'b0; write = 1'b0; rst = 1'b0;
      repeat (3) @(negedge clk);
      bus(0, 0, 0);
      check("arst_shadow_fcw", data_out, 32'd0);
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
